// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter and the data_memory it fronts.
package dmem_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned DEPTH_DEF      = 1025;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter, bundled.
// slave = arbiter view; master = requesters plus data_memory view.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                  p0_req;
  logic                  p0_we;
  logic [DATA_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_ack;
  logic                  p0_err;
  logic [DATA_WIDTH-1:0] p0_rdata;

  logic                  p1_req;
  logic                  p1_we;
  logic [DATA_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_ack;
  logic                  p1_err;
  logic [DATA_WIDTH-1:0] p1_rdata;

  logic [DATA_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data_to_write;
  logic                  mem_WE;
  logic [DATA_WIDTH-1:0] mem_data_read;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_ack, p0_err, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ack, p1_err, p1_rdata,
    output mem_address, mem_data_to_write, mem_WE,
    input  mem_data_read
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_ack, p0_err, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ack, p1_err, p1_rdata,
    input  mem_address, mem_data_to_write, mem_WE,
    output mem_data_read
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the port that did not
// win last time is chosen.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic owner
);

  // Pick the single requester, or the one other than last_grant on a tie.
  always_comb begin
    grant_valid = req0 | req1;
    owner       = 1'b0;
    if (req0 && req1) begin
      owner = ~last_grant;
    end else if (req1) begin
      owner = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the CPU load/store stage (port 0)
// and a debug/DMA loader (port 1). One access at a time: IDLE -> ACCESS -> DONE.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(DEPTH);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic                  last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  gnt_valid;
  logic                  gnt_owner;
  logic [DATA_WIDTH-1:0] sel_addr;

  rr_arb2 u_rr_arb2 (
    .req0        (bus.p0_req),
    .req1        (bus.p1_req),
    .last_grant  (last_grant_q),
    .grant_valid (gnt_valid),
    .owner       (gnt_owner)
  );

  assign sel_addr = gnt_owner ? bus.p1_addr : bus.p0_addr;

  // Next-state: latch the granted request in IDLE, capture read data in ACCESS.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    err_d        = err_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d      = gnt_owner;
          we_d         = gnt_owner ? bus.p1_we : bus.p0_we;
          addr_d       = sel_addr;
          wdata_d      = gnt_owner ? bus.p1_wdata : bus.p0_wdata;
          err_d        = (sel_addr >= DEPTH_W);
          last_grant_d = gnt_owner;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = (err_q || we_q) ? '0 : bus.mem_data_read;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Outputs decoded from registered state only, so mem_WE cannot glitch.
  always_comb begin
    bus.mem_address       = addr_q;
    bus.mem_data_to_write = wdata_q;
    bus.mem_WE            = (state_q == ACCESS) & we_q & ~err_q;
    bus.p0_ack            = 1'b0;
    bus.p0_err            = 1'b0;
    bus.p0_rdata          = '0;
    bus.p1_ack            = 1'b0;
    bus.p1_err            = 1'b0;
    bus.p1_rdata          = '0;
    if (state_q == DONE) begin
      if (owner_q) begin
        bus.p1_ack   = 1'b1;
        bus.p1_err   = err_q;
        bus.p1_rdata = rdata_q;
      end else begin
        bus.p0_ack   = 1'b1;
        bus.p0_err   = err_q;
        bus.p0_rdata = rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a transaction-timing model of the arbiter.
module tb_dmem_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1025;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  dmem_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Stand-in for data_memory: combinational read, write on posedge.
  logic [31:0] env_mem [0:2047];
  assign bus.mem_data_read = (bus.mem_address < 32'd2048) ? env_mem[bus.mem_address[10:0]] : 32'hBAD0_BAD0;
  always @(posedge clk) if (bus.mem_WE) env_mem[bus.mem_address[10:0]] <= bus.mem_data_to_write;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h0F0F_1234;
  endfunction

  // Requester state
  logic        rq_req   [2];
  logic        rq_we    [2];
  logic [31:0] rq_addr  [2];
  logic [31:0] rq_wdata [2];
  logic        rq_hold  [2];
  logic        rq_auto;

  // Reference model: one transaction occupies the memory for three cycles
  logic [31:0] ref_mem [0:2047];
  logic        last;
  int          free_at, ack_cyc, we_cyc, grant_cyc;
  logic        ack_port, ack_err, w_pend;
  logic [31:0] ack_rdata, w_addr, w_data, g_addr, g_wdata, m_addr, m_wdata;

  task automatic model_reset();
    last = 1'b1; free_at = 0; ack_cyc = -1; we_cyc = -1; grant_cyc = -1;
    ack_port = 1'b0; ack_err = 1'b0; ack_rdata = '0; w_pend = 1'b0;
    m_addr = '0; m_wdata = '0; g_addr = '0; g_wdata = '0; w_addr = '0; w_data = '0;
  endtask

  // Predict what the arbiter does with the requests it sees at edge e.
  task automatic model_sample(input int e);
    logic o, err;
    if (e < free_at) return;
    if (!rq_req[0] && !rq_req[1]) return;
    if (rq_req[0] && rq_req[1]) o = ~last;
    else                        o = rq_req[1];
    err       = (rq_addr[o] >= 32'(DEPTH));
    last      = o;
    grant_cyc = e;
    g_addr    = rq_addr[o];
    g_wdata   = rq_wdata[o];
    ack_cyc   = e + 1;
    ack_port  = o;
    ack_err   = err;
    ack_rdata = (err || rq_we[o]) ? 32'h0 : ref_mem[rq_addr[o][10:0]];
    we_cyc    = (rq_we[o] && !err) ? e : -1;
    if (rq_we[o] && !err) begin
      w_pend = 1'b1; w_addr = rq_addr[o]; w_data = rq_wdata[o];
    end
    free_at = e + 3;
  endtask

  task automatic check_cycle();
    logic exp_ack, got_ack, got_err;
    logic [31:0] got_rd;
    check_eq("mem_WE", 64'(bus.mem_WE), 64'(cyc == we_cyc));
    check_eq("mem_address", 64'(bus.mem_address), 64'(m_addr));
    check_eq("mem_data_to_write", 64'(bus.mem_data_to_write), 64'(m_wdata));
    for (int p = 0; p < 2; p++) begin
      exp_ack = (cyc == ack_cyc) && (ack_port == p[0]);
      got_ack = p[0] ? bus.p1_ack   : bus.p0_ack;
      got_err = p[0] ? bus.p1_err   : bus.p0_err;
      got_rd  = p[0] ? bus.p1_rdata : bus.p0_rdata;
      check_eq(p[0] ? "p1_ack" : "p0_ack", 64'(got_ack), 64'(exp_ack));
      check_eq(p[0] ? "p1_err" : "p0_err", 64'(got_err), 64'(exp_ack & ack_err));
      check_eq(p[0] ? "p1_rdata" : "p0_rdata", 64'(got_rd), 64'(exp_ack ? ack_rdata : 32'h0));
    end
  endtask

  task automatic new_tx(input int p);
    int unsigned sel;
    sel = $urandom % 10;
    rq_req[p] = 1'b1;
    rq_we[p]  = 1'($urandom % 2);
    if (sel < 6)      rq_addr[p] = $urandom % 24;
    else if (sel < 8) rq_addr[p] = 32'd1020 + ($urandom % 10);
    else if (sel < 9) rq_addr[p] = $urandom;
    else              rq_addr[p] = $urandom % 1025;
    rq_wdata[p] = $urandom;
  endtask

  task automatic set_tx(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    rq_req[p] = 1'b1; rq_we[p] = we; rq_addr[p] = addr; rq_wdata[p] = wdata;
  endtask

  task automatic drive();
    bus.p0_req = rq_req[0]; bus.p0_we = rq_we[0]; bus.p0_addr = rq_addr[0]; bus.p0_wdata = rq_wdata[0];
    bus.p1_req = rq_req[1]; bus.p1_we = rq_we[1]; bus.p1_addr = rq_addr[1]; bus.p1_wdata = rq_wdata[1];
  endtask

  // One clock: check outputs at negedge, update requesters, predict next edge.
  task automatic step();
    logic acked;
    check_cycle();
    for (int p = 0; p < 2; p++) begin
      acked = (cyc == ack_cyc) && (ack_port == p[0]);
      if (acked) begin
        if (rq_auto) begin
          if (($urandom % 2) == 0) new_tx(p);
          else rq_req[p] = 1'b0;
        end else if (!rq_hold[p]) begin
          rq_req[p] = 1'b0;
        end
      end else if (rq_auto && !rq_req[p] && ($urandom % 10) < 3) begin
        new_tx(p);
      end else if (rq_auto && rq_req[p] && ack_port == p[0] && cyc == grant_cyc && ($urandom % 4) == 0) begin
        rq_addr[p]  = $urandom;
        rq_wdata[p] = $urandom;
      end
    end
    drive();
    if (rst_n) model_sample(cyc + 1);
    @(posedge clk);
    cyc++;
    if (w_pend && cyc == we_cyc + 1) begin
      ref_mem[w_addr[10:0]] = w_data;
      w_pend = 1'b0;
    end
    if (cyc == grant_cyc) begin
      m_addr = g_addr; m_wdata = g_wdata;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int budget;
    budget = 60;
    rq_auto = 1'b0; rq_hold[0] = 1'b0; rq_hold[1] = 1'b0;
    while ((rq_req[0] || rq_req[1] || cyc < free_at) && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check_eq("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int nmis;
    for (int i = 0; i < 2048; i++) begin
      env_mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    for (int p = 0; p < 2; p++) begin
      rq_req[p] = 1'b0; rq_we[p] = 1'b0; rq_addr[p] = '0; rq_wdata[p] = '0; rq_hold[p] = 1'b0;
    end
    rq_auto = 1'b0;
    rst_n = 1'b0;
    model_reset();
    drive();
    @(negedge clk);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // p0 write 5, then p1 reads it back
    set_tx(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    repeat (4) step();
    check_eq("mem5_written", 64'(env_mem[5]), 64'h0000_0000_DEAD_BEEF);
    set_tx(1, 1'b0, 32'd5, 32'h0);
    repeat (4) step();

    // Both held: grants must alternate
    rq_hold[0] = 1'b1; rq_hold[1] = 1'b1;
    set_tx(0, 1'b0, 32'd3, 32'h0);
    set_tx(1, 1'b0, 32'd4, 32'h0);
    repeat (13) step();
    drain();

    // Boundary addresses
    set_tx(0, 1'b1, 32'd1025, 32'd1);
    repeat (4) step();
    check_eq("mem1025_untouched", 64'(env_mem[1025]), 64'(init_word(1025)));
    set_tx(0, 1'b1, 32'd1024, 32'd1);
    repeat (4) step();
    check_eq("mem1024_written", 64'(env_mem[1024]), 64'd1);

    // Reset during the ACCESS cycle of a p1 write
    set_tx(1, 1'b1, 32'd20, 32'h1234_5678);
    step();
    check_eq("pre_reset_we", 64'(bus.mem_WE), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("reset_we_async", 64'(bus.mem_WE), 64'd0);
    check_eq("reset_p1_ack", 64'(bus.p1_ack), 64'd0);
    model_reset();
    set_tx(0, 1'b0, 32'd20, 32'h0);
    repeat (2) step();
    check_eq("mem20_unchanged", 64'(env_mem[20]), 64'(init_word(20)));
    rst_n = 1'b1;
    repeat (3) step();
    drain();

    // Address change during ACCESS is ignored; held req reissues with new addr
    rq_hold[0] = 1'b1;
    set_tx(0, 1'b0, 32'd7, 32'h0);
    step();
    rq_addr[0] = 32'd9;
    repeat (4) step();
    drain();

    // Random traffic
    rq_auto = 1'b1;
    repeat (900) step();
    drain();

    nmis = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (env_mem[i] !== ref_mem[i]) nmis++;
    check_eq("final_mem_image", 64'(nmis), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
